// File: rtl/io_out_queue.sv
// io_out_queue: first-word-fall-through queue between processor output strobes and a port consumer
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (pointers, count, ovf)
//   out_en    processor output strobe, one write per cycle while high
//   addr_out  processor output port address
//   data_out  processor output data
//   m_valid   head entry available (count != 0)
//   m_ready   consumer accepts head entry
//   m_addr    port address of head entry
//   m_data    data of head entry
//   count     occupied entries, 0..DEPTH
//   full      count == DEPTH
//   afull     count >= AFULL, drives processor itr
//   ovf       sticky overflow, set when a write is dropped
//   ovf_clr   synchronous clear of ovf; a same-cycle overflow wins
module io_out_queue #(
   parameter int NUBITS = 32,
   parameter int NUIOOU = 8,
   parameter int DEPTH  = 8,
   parameter int AFULL  = 6,
   localparam int AW = $clog2(NUIOOU),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_en,
   input  logic [AW-1:0]     addr_out,
   input  logic [NUBITS-1:0] data_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [AW-1:0]     m_addr,
   output logic [NUBITS-1:0] m_data,
   output logic [PW:0]       count,
   output logic              full,
   output logic              afull,
   output logic              ovf,
   input  logic              ovf_clr
);
   logic [AW+NUBITS-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, drop;
   assign count   = count_q;
   assign m_valid = count_q != '0;
   assign full    = count_q == (PW+1)'(DEPTH);
   assign afull   = count_q >= (PW+1)'(AFULL);
   assign ovf     = ovf_q;
   assign {m_addr, m_data} = mem[rd_ptr_q];
   assign pop  = m_valid & m_ready;
   // a full queue still accepts a write when the head leaves in the same cycle
   assign push = out_en & (~full | pop);
   assign drop = out_en & full & ~pop;
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = (push & ~pop) ? count_q + (PW+1)'(1) :
                 (pop & ~push) ? count_q - (PW+1)'(1) : count_q;
      ovf_d    = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end
   // storage is left unreset; its contents are only observed while m_valid is high
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {addr_out, data_out};
   end
endmodule
